// File: rtl/huff_pkg.sv
// Shared Huffman code definitions for the weight-stream encoder and the
// on-chip decoder, so both sides always agree on the table.
package huff_pkg;

  localparam int HUFF_BW      = 4;
  localparam int MAX_CODE_LEN = 8;
  localparam int HUFF_LEN_W   = 4;

  localparam logic [3:0] ESC_PREFIX = 4'b1111;

  // Codes are stored left-aligned in an 8-bit field, unused low bits zero.
  localparam logic [7:0] CODE_SYM_0 = 8'b0000_0000;
  localparam logic [7:0] CODE_SYM_1 = 8'b1000_0000;
  localparam logic [7:0] CODE_SYM_F = 8'b1010_0000;
  localparam logic [7:0] CODE_SYM_2 = 8'b1100_0000;
  localparam logic [7:0] CODE_SYM_E = 8'b1101_0000;
  localparam logic [7:0] CODE_SYM_3 = 8'b1110_0000;
  localparam logic [7:0] CODE_SYM_D = 8'b1110_1000;

  localparam logic [3:0] LEN_SYM_0  = 4'd1;
  localparam logic [3:0] LEN_SYM_1  = 4'd3;
  localparam logic [3:0] LEN_SYM_F  = 4'd3;
  localparam logic [3:0] LEN_SYM_2  = 4'd4;
  localparam logic [3:0] LEN_SYM_E  = 4'd4;
  localparam logic [3:0] LEN_SYM_3  = 4'd5;
  localparam logic [3:0] LEN_SYM_D  = 4'd5;
  localparam logic [3:0] LEN_ESC    = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } huff_state_t;

  typedef struct packed {
    logic [MAX_CODE_LEN-1:0] code;
    logic [HUFF_LEN_W-1:0]   len;
  } huff_code_t;

  // Symbol -> left-aligned code and its length; unlisted symbols escape
  // with the prefix followed by their raw 4 bits.
  function automatic huff_code_t huff_lookup(input logic [HUFF_BW-1:0] sym);
    huff_code_t c;
    case (sym)
      4'h0:    begin c.code = CODE_SYM_0; c.len = LEN_SYM_0; end
      4'h1:    begin c.code = CODE_SYM_1; c.len = LEN_SYM_1; end
      4'hF:    begin c.code = CODE_SYM_F; c.len = LEN_SYM_F; end
      4'h2:    begin c.code = CODE_SYM_2; c.len = LEN_SYM_2; end
      4'hE:    begin c.code = CODE_SYM_E; c.len = LEN_SYM_E; end
      4'h3:    begin c.code = CODE_SYM_3; c.len = LEN_SYM_3; end
      4'hD:    begin c.code = CODE_SYM_D; c.len = LEN_SYM_D; end
      default: begin c.code = {ESC_PREFIX, sym}; c.len = LEN_ESC; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/huff_code_lut.sv
// Combinational symbol-to-code lookup for the Huffman encoder.
module huff_code_lut
  import huff_pkg::*;
(
  input  logic [HUFF_BW-1:0]      i_sym,
  output logic [MAX_CODE_LEN-1:0] o_code,
  output logic [HUFF_LEN_W-1:0]   o_len
);

  huff_code_t w_entry;

  // Table lookup through the shared package function.
  always_comb begin
    w_entry = huff_lookup(i_sym);
    o_code  = w_entry.code;
    o_len   = w_entry.len;
  end

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: packs row-packed weight symbols into 32-bit prefix-coded
// words for xmem, with a flush/done handshake to close a stream.
//
// state  | meaning
// IDLE   | ready for a new word or a flush request
// ENCODE | appending one symbol per cycle, stalls if the accumulator is full
// FLUSH  | drain remaining bits, zero-padding the final partial word
// DONE   | wait for the last word to leave, then pulse done
module huffman_encoder
  import huff_pkg::*;
#(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int out_w = 32,
  parameter int cnt_w = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw*row-1:0]  in_word,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [out_w-1:0]   out_word,
  output logic               out_last,
  output logic [cnt_w-1:0]   total_bits,
  output logic               done
);

  localparam int ACC_W  = out_w + MAX_CODE_LEN;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int SIDX_W = (row > 1) ? $clog2(row) : 1;

  localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(out_w);
  localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(row - 1);

  huff_state_t             r_state;
  logic [bw*row-1:0]       r_word;
  logic [SIDX_W-1:0]       r_sym_idx;
  logic [ACC_W-1:0]        r_acc;
  logic [FILL_W-1:0]       r_fill;
  logic [out_w-1:0]        r_out_word;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [cnt_w-1:0]        r_total;
  logic                    r_done;
  logic                    r_in_ready;

  logic                    w_free;
  logic                    w_xfer;
  logic [ACC_W-1:0]        w_acc_shift;
  logic [FILL_W-1:0]       w_fill_post;
  logic                    w_can_append;
  logic [bw-1:0]           w_sym;
  logic [MAX_CODE_LEN-1:0] w_code;
  logic [HUFF_LEN_W-1:0]   w_len;
  logic [ACC_W-1:0]        w_code_ext;
  logic [cnt_w:0]          w_sum;
  logic [cnt_w-1:0]        w_total_next;

  huff_code_lut u_lut (
    .i_sym  (w_sym),
    .o_code (w_code),
    .o_len  (w_len)
  );

  // Output-transfer decision and the post-transfer accumulator view that the
  // append stage builds on, so a word can leave and a symbol enter together.
  always_comb begin
    w_sym        = r_word[int'(r_sym_idx)*bw +: bw];
    w_free       = !r_out_valid || out_ready;
    w_xfer       = w_free && (r_fill >= FILL_OUT);
    w_acc_shift  = w_xfer ? {r_acc[ACC_W-out_w-1:0], {out_w{1'b0}}} : r_acc;
    w_fill_post  = w_xfer ? (r_fill - FILL_OUT) : r_fill;
    w_can_append = (w_fill_post <= FILL_OUT);
    w_code_ext   = {w_code, {(ACC_W-MAX_CODE_LEN){1'b0}}} >> w_fill_post;
    w_sum        = {1'b0, r_total} + (cnt_w+1)'(w_len);
    w_total_next = w_sum[cnt_w] ? {cnt_w{1'b1}} : w_sum[cnt_w-1:0];
  end

  // Control FSM with accumulator, output register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_sym_idx   <= '0;
      r_acc       <= '0;
      r_fill      <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_total     <= '0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_out_word  <= r_acc[ACC_W-1 -: out_w];
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
      end
      r_acc  <= w_acc_shift;
      r_fill <= w_fill_post;

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word     <= in_word;
            r_sym_idx  <= '0;
            r_state    <= ENCODE;
            r_in_ready <= 1'b0;
          end else if (flush) begin
            r_state    <= FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        ENCODE: begin
          if (w_can_append) begin
            r_acc   <= w_acc_shift | w_code_ext;
            r_fill  <= w_fill_post + FILL_W'(w_len);
            r_total <= w_total_next;
            if (r_sym_idx == SIDX_LAST) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
            end else begin
              r_sym_idx <= r_sym_idx + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Whole words drain through the normal transfer path first; only a
          // partial remainder is padded out here.
          if (r_fill == '0) begin
            r_state <= DONE;
          end else if (r_fill < FILL_OUT && w_free) begin
            r_out_word  <= r_acc[ACC_W-1 -: out_w];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_acc       <= '0;
            r_fill      <= '0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_done     <= 1'b1;
            r_total    <= '0;
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_word   = r_out_word;
  assign out_last   = r_out_last;
  assign total_bits = r_total;
  assign done       = r_done;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder with hand-computed bitstreams.
module tb_huffman_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic [15:0] total_bits;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_word[$];
  logic        q_last[$];

  huffman_encoder #(.bw(4), .row(8), .out_w(32), .cnt_w(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_last   (out_last),
    .total_bits (total_bits),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Inputs move at posedge+1, so the negedge sees a settled handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_word.push_back(out_word);
      q_last.push_back(out_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string who);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_ready_timeout: in_ready=%0b required 1", who, in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    wait_ready("send");
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush(output logic [15:0] tb_before, output int done_cnt,
                          output logic [15:0] tb_after);
    wait_ready("flush");
    tb_before = total_bits;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    tick();
    tb_after = total_bits;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_word = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_word !== 32'h0) begin n_err++; $display("FAIL rst_out_word: got %h want 0", out_word); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_cmp++; if (total_bits !== 16'd0) begin n_err++; $display("FAIL rst_total: got %0d want 0", total_bits); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
  endtask

  task automatic test_single();
    int base = q_word.size();
    logic [15:0] tb0, tb1;
    int dc;
    send_word(32'h00000001);
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 1) begin n_err++; $display("FAIL single_count: got %0d want %0d", q_word.size() - base, 1); end
    n_cmp++; if (q_word[base] !== 32'h80000000) begin n_err++; $display("FAIL single_word: got %h want 80000000", q_word[base]); end
    n_cmp++; if (q_last[base] !== 1'b1) begin n_err++; $display("FAIL single_last: got %b want 1", q_last[base]); end
    n_cmp++; if (tb0 !== 16'd10) begin n_err++; $display("FAIL single_total: got %0d want 10", tb0); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL single_done: got %0d pulses want 1", dc); end
    n_cmp++; if (tb1 !== 16'd0) begin n_err++; $display("FAIL single_total_clr: got %0d want 0", tb1); end
  endtask

  task automatic test_zero_words();
    int base = q_word.size();
    logic [15:0] tb0, tb1;
    int dc;
    repeat (4) send_word(32'h00000000);
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 1) begin n_err++; $display("FAIL zero_count: got %0d want 1", q_word.size() - base); end
    n_cmp++; if (q_word[base] !== 32'h00000000) begin n_err++; $display("FAIL zero_word: got %h want 00000000", q_word[base]); end
    n_cmp++; if (q_last[base] !== 1'b0) begin n_err++; $display("FAIL zero_last: got %b want 0", q_last[base]); end
    n_cmp++; if (tb0 !== 16'd32) begin n_err++; $display("FAIL zero_total: got %0d want 32", tb0); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL zero_done: got %0d pulses want 1", dc); end
  endtask

  task automatic test_escape();
    int base = q_word.size();
    logic [15:0] tb0, tb1;
    int dc;
    send_word(32'h77777777);
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 2) begin n_err++; $display("FAIL esc_count: got %0d want 2", q_word.size() - base); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (q_word[base+i] !== 32'hF7F7F7F7) begin n_err++; $display("FAIL esc_word%0d: got %h want F7F7F7F7", i, q_word[base+i]); end
      n_cmp++; if (q_last[base+i] !== 1'b0) begin n_err++; $display("FAIL esc_last%0d: got %b want 0", i, q_last[base+i]); end
    end
    n_cmp++; if (tb0 !== 16'd64) begin n_err++; $display("FAIL esc_total: got %0d want 64", tb0); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL esc_done: got %0d pulses want 1", dc); end
  endtask

  task automatic test_mixed();
    int base = q_word.size();
    logic [15:0] tb0, tb1;
    int dc;
    logic [63:0] bits;
    logic [3:0] exp_sym [8];
    logic [3:0] sym;
    int p;
    exp_sym = '{4'h0, 4'h3, 4'hF, 4'hD, 4'h1, 4'h2, 4'hF, 4'hE};
    send_word(32'hEF21DF30);
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 1) begin n_err++; $display("FAIL mix_count: got %0d want 1", q_word.size() - base); end
    n_cmp++; if (q_word[base] !== 32'h72F665D0) begin n_err++; $display("FAIL mix_word: got %h want 72F665D0", q_word[base]); end
    n_cmp++; if (q_last[base] !== 1'b1) begin n_err++; $display("FAIL mix_last: got %b want 1", q_last[base]); end
    n_cmp++; if (tb0 !== 16'd28) begin n_err++; $display("FAIL mix_total: got %0d want 28", tb0); end
    bits = {q_word[base], 32'h0};
    p = 63;
    for (int k = 0; k < 8; k++) begin
      if (bits[p] == 1'b0) begin
        sym = 4'h0; p -= 1;
      end else if (bits[p-1] == 1'b0) begin
        sym = bits[p-2] ? 4'hF : 4'h1; p -= 3;
      end else if (bits[p-2] == 1'b0) begin
        sym = bits[p-3] ? 4'hE : 4'h2; p -= 4;
      end else if (bits[p-3] == 1'b0) begin
        sym = bits[p-4] ? 4'hD : 4'h3; p -= 5;
      end else begin
        sym = bits[p-4 -: 4]; p -= 8;
      end
      n_cmp++; if (sym !== exp_sym[k]) begin n_err++; $display("FAIL mix_decode%0d: got %h want %h", k, sym, exp_sym[k]); end
    end
    n_cmp++; if (p !== 63 - 28) begin n_err++; $display("FAIL mix_decode_len: got %0d bits want 28", 63 - p); end
  endtask

  task automatic test_back_to_back_stall();
    int base = q_word.size();
    logic [15:0] tb0, tb1;
    int dc;
    out_ready = 1'b0;
    send_word(32'h77777777);
    send_word(32'h77777777);
    repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (out_word !== 32'hF7F7F7F7) begin n_err++; $display("FAIL stall_word%0d: got %h want F7F7F7F7", i, out_word); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready%0d: got %b want 0", i, in_ready); end
      n_cmp++; if (total_bits !== 16'd72) begin n_err++; $display("FAIL stall_total%0d: got %0d want 72", i, total_bits); end
    end
    n_cmp++; if (q_word.size() !== base) begin n_err++; $display("FAIL stall_no_accept: got %0d words want 0", q_word.size() - base); end
    tick();
    out_ready = 1'b1;
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 4) begin n_err++; $display("FAIL stall_count: got %0d want 4", q_word.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (q_word[base+i] !== 32'hF7F7F7F7) begin n_err++; $display("FAIL stall_out%0d: got %h want F7F7F7F7", i, q_word[base+i]); end
      n_cmp++; if (q_last[base+i] !== 1'b0) begin n_err++; $display("FAIL stall_last%0d: got %b want 0", i, q_last[base+i]); end
    end
    n_cmp++; if (tb0 !== 16'd128) begin n_err++; $display("FAIL stall_total: got %0d want 128", tb0); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL stall_done: got %0d pulses want 1", dc); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [15:0] tb0, tb1;
    int dc;
    wait_ready("rstmid");
    base = q_word.size();
    in_valid = 1'b1;
    in_word  = 32'h77777777;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (total_bits !== 16'd32) begin n_err++; $display("FAIL rstmid_progress: got %0d want 32", total_bits); end
    reset = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (total_bits !== 16'd0) begin n_err++; $display("FAIL rstmid_total: got %0d want 0", total_bits); end
    reset = 1'b0;
    tick();
    n_cmp++; if (q_word.size() !== base) begin n_err++; $display("FAIL rstmid_no_out: got %0d words want 0", q_word.size() - base); end
    send_word(32'h00000001);
    do_flush(tb0, dc, tb1);
    n_cmp++; if (q_word.size() !== base + 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", q_word.size() - base); end
    n_cmp++; if (q_word[base] !== 32'h80000000) begin n_err++; $display("FAIL rstmid_word: got %h want 80000000", q_word[base]); end
    n_cmp++; if (q_last[base] !== 1'b1) begin n_err++; $display("FAIL rstmid_last: got %b want 1", q_last[base]); end
    n_cmp++; if (tb0 !== 16'd10) begin n_err++; $display("FAIL rstmid_total2: got %0d want 10", tb0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_words();
    test_escape();
    test_mixed();
    test_back_to_back_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Compresses weight words into the prefix-coded bitstream that the core's on-chip Huffman decoder consumes.
- Input is one row-packed weight word: row symbols of bw bits each.
- Output is 32-bit packed bitstream words, written into xmem starting at the kernel region (address 11'b10000000000).
- Sits ahead of xmem and is the transmitter counterpart of the huff_valid / data_ready_huff decoder path. The code table is fixed and identical to the decoder's.

Parameters:
- bw, 4, bits per weight symbol; the code table assumes 4.
- row, 8, symbols per input word.
- out_w, 32, output word width; equals the xmem data width (bw*row).
- cnt_w, 16, width of the total-bit counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_word is offered.
- in_ready  out  1  encoder accepts in_word this cycle.
- in_word  in  bw*row  symbols; symbol k is in_word[bw*k+bw-1 : bw*k].
- flush  in  1  one-cycle pulse: terminate the stream. Sampled only in IDLE.
- out_valid  out  1  out_word holds a valid packed word.
- out_ready  in  1  consumer takes out_word.
- out_word  out  out_w  packed bitstream; first code bit at bit 31.
- out_last  out  1  qualifies out_word as the final, zero-padded word.
- total_bits  out  cnt_w  code bits emitted since the last done (padding excluded).
- done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_word=0, out_last=0, total_bits=0, done=0, fill=0, sym_idx=0, accumulator cleared. Reset mid-operation discards all buffered bits immediately; nothing partial is emitted.
- Code table (symbol hex -> code, MSB first), prefix-free and complete, max length 8:
  - 0 -> 0
  - 1 -> 100
  - F -> 101
  - 2 -> 1100
  - E -> 1101
  - 3 -> 11100
  - D -> 11101
  - any other s -> 1111 followed by the 4 raw bits of s (8 bits total).
- Accumulator: 40 bits, left-aligned; fill counts valid bits (0..40).
- States:
  - IDLE: in_ready=1. If in_valid, latch in_word, set sym_idx=0, go to ENCODE. Otherwise, if flush, go to FLUSH. If in_valid and flush occur together, in_valid wins and flush is ignored.
  - ENCODE: in_ready=0. One symbol per cycle, in order sym_idx 0..row-1. After symbol row-1 is appended, return to IDLE. A new word costs row+1 cycles.
  - FLUSH:
    - If fill>0 and the output register is free: zero-pad to out_w, load out_word, assert out_last, set fill=0, go to DONE.
    - If fill==0: go straight to DONE.
  - DONE: wait until out_valid=0, then pulse done=1 for one cycle, clear total_bits, go to IDLE.
- Per-cycle ordering:
  - The output register is free when out_valid=0, or when out_valid=1 and out_ready=1 this cycle.
  - If free and fill>=32: top 32 bits go to out_word, out_valid=1, fill-=32, remaining bits shift up.
  - In ENCODE, the current symbol is appended only if the post-transfer fill <=32. Otherwise sym_idx holds (stall). This guarantees the 40-bit accumulator never overflows.
- total_bits increments by the code length on each append and saturates at 2^cnt_w-1.
- out_valid falls on the cycle after acceptance unless a new word transfers that same cycle. out_word and out_last are stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package huff_pkg holds:
  - code table constants (code value, length per symbol);
  - escape prefix 4'b1111;
  - MAX_CODE_LEN=8;
  - state enum (IDLE, ENCODE, FLUSH, DONE).
  The decoder imports the same package.
- One sub-module, huff_code_lut: combinational, symbol -> {code[7:0] left-aligned, len[3:0]}.

Test Plan:
- in_word=32'h00000001, then flush, out_ready=1 -> one word 32'h80000000, out_last=1, total_bits=10, done pulse one cycle later.
- Four words 32'h00000000, then flush -> one word 32'h00000000 with out_last=0 after the 4th word; no padded word; done pulse; total_bits=32 before clearing.
- in_word=32'h77777777, then flush -> two words 32'hF7F7F7F7 (last one out_last=0); done; total_bits=64.
- Backpressure: out_ready=0 while streaming 32'h77777777 words -> out_word stable, sym_idx stalls once fill reaches 33..40, no bits lost; release out_ready -> bitstream is identical to the no-stall case.
- in_word=32'hEF21DF30 -> decode the concatenated output with the reference table; symbols must come back as 0,3,F,D,1,2,F,E.
- reset asserted in ENCODE at sym_idx=4 -> next cycle out_valid=0, in_ready=1, total_bits=0; a following 32'h00000001 + flush yields exactly 32'h80000000.
